// File: rtl/dma_copy.sv
// dma_copy: memory-bus initiator that copies a block of 32-bit words from a
// source to a destination address. Each word is one read transaction followed
// by one write transaction on the sel/read/write_mask/ready bus. Transactions
// never overlap.
//
// Optional feature: define DMA_COPY_TIMEOUT_EN to enable a per-transaction
// wait-state limit (TIMEOUT_CYCLES). On expiry the transfer is abandoned and
// error_out pulses together with done_out. Without the macro the engine waits
// indefinitely for ready_in and error_out is tied low.
module dma_copy #(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_in,
  input  logic [31:0]          src_in,
  input  logic [31:0]          dst_in,
  input  logic [LEN_WIDTH-1:0] len_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic [31:0]          address_out,
  output logic                 sel_out,
  output logic                 read_out,
  input  logic [31:0]          read_value_in,
  output logic [3:0]           write_mask_out,
  output logic [31:0]          write_value_out,
  input  logic                 ready_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Low two address bits are forced to zero: the engine only moves whole words.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_STEP = 32'd4;

  logic [1:0]           state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [31:0]          data_q, data_d;

`ifdef DMA_COPY_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              timeout_s;

  // Wait-state limit reached in this cycle and the responder still has not answered.
  always_comb begin
    timeout_s = 1'b0;
    if (((state_q == S_READ) || (state_q == S_WRITE)) && !ready_in && (wait_q == WAIT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end
`endif

  // Next-state and datapath update for the copy sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    data_d  = data_q;
`ifdef DMA_COPY_TIMEOUT_EN
    wait_d  = {WAIT_W{1'b0}};
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in && (len_in != {LEN_WIDTH{1'b0}})) begin
          src_d   = src_in & WORD_MASK;
          dst_d   = dst_in & WORD_MASK;
          count_d = len_in;
          state_d = S_READ;
        end else if (start_in) begin
          // Zero-length request: report completion without touching the bus.
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (ready_in) begin
          data_d  = read_value_in;
          state_d = S_WRITE;
`ifdef DMA_COPY_TIMEOUT_EN
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
`else
        end else begin
`endif
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (ready_in) begin
          src_d   = src_q + WORD_STEP;
          dst_d   = dst_q + WORD_STEP;
          count_d = count_q - LEN_WIDTH'(1);
          if (count_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
`ifdef DMA_COPY_TIMEOUT_EN
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
`else
        end else begin
`endif
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      count_q <= {LEN_WIDTH{1'b0}};
      data_q  <= 32'd0;
`ifdef DMA_COPY_TIMEOUT_EN
      wait_q  <= {WAIT_W{1'b0}};
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      data_q  <= data_d;
`ifdef DMA_COPY_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  // Bus drive and status decode; everything is zero outside READ/WRITE.
  always_comb begin
    address_out     = 32'd0;
    sel_out         = 1'b0;
    read_out        = 1'b0;
    write_mask_out  = 4'b0000;
    write_value_out = 32'd0;
    busy_out        = 1'b0;
    done_out        = 1'b0;
    case (state_q)
      S_READ: begin
        address_out = src_q;
        sel_out     = 1'b1;
        read_out    = 1'b1;
        busy_out    = 1'b1;
      end
      S_WRITE: begin
        address_out     = dst_q;
        sel_out         = 1'b1;
        write_mask_out  = 4'b1111;
        write_value_out = data_q;
        busy_out        = 1'b1;
      end
      S_DONE: begin
        done_out = 1'b1;
      end
      default: begin
        done_out = 1'b0;
      end
    endcase
  end

`ifdef DMA_COPY_TIMEOUT_EN
  assign error_out = (state_q == S_DONE) && err_q;
`else
  assign error_out = 1'b0;
`endif

endmodule
